// File: rtl/lifo_stack_top.sv
// lifo_stack_top: LIFO stack of WIDTH-bit words controlled by a packed push/pop/data vector.
// Push and pop are guarded at full/empty, so sp never wraps; push+pop together is a no-op.
module lifo_stack_top #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH+1:0] vector_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty_flag,
  output logic             full_flag
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] sp;
  logic             push, pop, do_push, do_pop;
  logic [AW-1:0]    wr_idx, rd_idx;
  assign push       = vector_in[WIDTH+1];
  assign pop        = vector_in[WIDTH];
  assign empty_flag = sp == '0;
  assign full_flag  = sp == PTR_W'(DEPTH);
  assign do_push    = push && !pop && !full_flag;
  assign do_pop     = pop && !push && !empty_flag;
  assign wr_idx     = AW'(sp);
  assign rd_idx     = AW'(sp - 1'b1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp       <= '0;
      data_out <= '0;
    end else if (do_push) begin
      sp <= sp + 1'b1;
    end else if (do_pop) begin
      sp       <= sp - 1'b1;
      data_out <= mem[rd_idx];
    end
  end
  // Storage is never cleared; reset only suppresses the write.
  always_ff @(posedge clk)
    if (reset && do_push) mem[wr_idx] <= vector_in[WIDTH-1:0];
endmodule

// File: tb/tb_lifo_stack_top.sv
// tb_lifo_stack_top: directed scenarios plus random commands checked against a queue-based stack model.
module tb_lifo_stack_top;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] vector_in = '0;
  logic [3:0] data_out;
  logic       empty_flag, full_flag;
  int         n_cmp = 0, n_err = 0;
  logic [3:0] q[$];
  logic [3:0] m_out = '0;

  lifo_stack_top dut (
    .clk(clk),
    .reset(reset),
    .vector_in(vector_in),
    .data_out(data_out),
    .empty_flag(empty_flag),
    .full_flag(full_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Applies one command for one edge, advances the model, compares all outputs.
  task automatic step(input logic rst_n, input logic psh, input logic pp, input logic [3:0] d);
    @(negedge clk);
    reset = rst_n;
    vector_in = {psh, pp, d};
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      m_out = '0;
    end else if (psh && !pp && q.size() < 8) q.push_back(d);
    else if (pp && !psh && q.size() > 0) m_out = q.pop_back();
    check("data_out", data_out, m_out);
    check("empty_flag", empty_flag, q.size() == 0);
    check("full_flag", full_flag, q.size() == 8);
  endtask

  task automatic push(input logic [3:0] d);
    step(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic pop();
    step(1'b1, 1'b0, 1'b1, 4'h0);
  endtask

  initial begin
    logic [3:0] s3 [8] = '{4'h0, 4'h1, 4'h7, 4'h6, 4'h0, 4'h1, 4'h7, 4'h6};
    logic [3:0] s2 [4] = '{4'h9, 4'hD, 4'hE, 4'hF};
    // Reset state, then pop while empty
    step(1'b0, 1'b0, 1'b0, 4'h0);
    check("rst_empty", empty_flag, 1'b1);
    check("rst_full", full_flag, 1'b0);
    check("rst_data", data_out, 4'h0);
    pop();
    check("empty_pop_data", data_out, 4'h0);
    // Push F,E,D,9, idle, pop four
    push(4'hF);
    check("s2_not_empty", empty_flag, 1'b0);
    push(4'hE);
    push(4'hD);
    push(4'h9);
    step(1'b1, 1'b0, 1'b0, 4'h5);
    for (int i = 0; i < 4; i++) begin
      pop();
      check("s2_pop", data_out, s2[i]);
    end
    check("s2_empty", empty_flag, 1'b1);
    // Fill to DEPTH, push past full
    for (int i = 0; i < 8; i++) push(s3[i]);
    check("s3_full", full_flag, 1'b1);
    push(4'h3);
    pop();
    check("s3_pop1", data_out, 4'h6);
    pop();
    check("s3_pop2", data_out, 4'h7);
    // Refill to full, then pop
    push(4'hD);
    push(4'h9);
    check("s4_full", full_flag, 1'b1);
    pop();
    check("s4_pop", data_out, 4'h9);
    check("s4_not_full", full_flag, 1'b0);
    // Down to 2 entries, then simultaneous push+pop twice
    while (q.size() > 2) pop();
    step(1'b1, 1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b1, 1'b1, 4'h5);
    check("s5_data", data_out, 4'h7);
    pop();
    check("s5_pop", data_out, 4'h1);
    // Reset with 5 entries stored
    while (q.size() < 5) push(4'($urandom));
    step(1'b0, 1'b1, 1'b0, 4'hA);
    check("s6_empty", empty_flag, 1'b1);
    check("s6_data", data_out, 4'h0);
    pop();
    check("s6_pop_ignored", data_out, 4'h0);
    // Random phases alternating push-heavy and pop-heavy
    for (int i = 0; i < 3000; i++) begin
      int r, bias;
      bias = ((i / 40) % 2 == 0) ? 65 : 30;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 99) < 2) step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom));
      else if (r < bias) push(4'($urandom));
      else if (r < 90) pop();
      else if (r < 95) step(1'b1, 1'b1, 1'b1, 4'($urandom));
      else step(1'b1, 1'b0, 1'b0, 4'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
